// File: rtl/bridge_pkg.sv
// Shared bridge data-slot definitions: table location, entry word overlays and
// the request-tracking state encoding used by the size override block.
package bridge_pkg;

    localparam logic [31:0] DATASLOT_TABLE_BASE  = 32'hF800_2000;
    localparam int          DATASLOT_ENTRY_BYTES = 8;

    // Word 0 of a table entry: the slot ID lives in the low half.
    typedef struct packed {
        logic [15:0] params;
        logic [15:0] id;
    } dataslot_even_t;

    // Word 1 of a table entry.
    typedef struct packed {
        logic [31:0] size_lower;
    } dataslot_odd_t;

    typedef enum logic {
        REQ_IDLE    = 1'b0,
        REQ_PENDING = 1'b1
    } req_state_t;

endpackage

// File: rtl/bridge_dataslot_size_channel.sv
// One override channel: remembers where its slot ID sits in the table and
// flags responses that target word 1 of that entry.
module bridge_dataslot_size_channel
    import bridge_pkg::*;
#(
    parameter logic [15:0] SLOT_ID = 16'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_learn_en,
    input  logic [15:0] i_rd_id,
    input  logic [28:0] i_req_addr_hi,
    input  logic        i_size_valid,
    output logic [31:0] o_base_address,
    output logic        o_base_found,
    output logic        o_match
);

    logic [28:0] r_base_hi;
    logic        r_found;
    logic        w_learn;

    // The first entry carrying our ID wins; later duplicates are ignored.
    assign w_learn = i_learn_en && !r_found && (i_rd_id == SLOT_ID);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_base_hi <= '0;
            r_found   <= 1'b0;
        end else if (w_learn) begin
            r_base_hi <= i_req_addr_hi;
            r_found   <= 1'b1;
        end
    end

    assign o_match        = r_found && i_size_valid && (i_req_addr_hi == r_base_hi);
    assign o_base_address = {r_base_hi, 3'b000};
    assign o_base_found   = r_found;

endmodule

// File: rtl/bridge_dataslot_size_override.sv
// Learns table entry addresses for configured slot IDs from host reads of word 0
// and substitutes a core-supplied size into reads of word 1 of those entries.
module bridge_dataslot_size_override
    import bridge_pkg::*;
#(
    parameter int          NUM_SLOTS                 = 2,
    parameter logic [15:0] SLOT_IDS [NUM_SLOTS]      = '{16'd0, 16'd1},
    parameter logic [31:0] TABLE_BASE                = DATASLOT_TABLE_BASE,
    parameter int          TABLE_ENTRIES             = 32
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic [31:0]               i_bridge_dataslot_in_addr,
    input  logic                      i_bridge_dataslot_in_wr,
    input  logic [31:0]               i_bridge_dataslot_in_wr_data,
    input  logic                      i_bridge_dataslot_in_rd,
    output logic [31:0]               o_bridge_dataslot_in_rd_data,
    output logic                      o_bridge_dataslot_in_rd_data_valid,

    output logic [31:0]               o_bridge_dataslot_out_addr,
    output logic                      o_bridge_dataslot_out_wr,
    output logic [31:0]               o_bridge_dataslot_out_wr_data,
    output logic                      o_bridge_dataslot_out_rd,
    input  logic [31:0]               i_bridge_dataslot_out_rd_data,
    input  logic                      i_bridge_dataslot_out_rd_data_valid,

    input  logic [NUM_SLOTS*32-1:0]   i_slot_size,
    input  logic [NUM_SLOTS-1:0]      i_slot_size_valid,
    output logic [NUM_SLOTS*32-1:0]   o_slot_base_address,
    output logic [NUM_SLOTS-1:0]      o_slot_base_found
);

    localparam logic [32:0] TABLE_END =
        {1'b0, TABLE_BASE} + 33'(DATASLOT_ENTRY_BYTES * TABLE_ENTRIES);

    req_state_t              r_state;
    req_state_t              w_next_state;
    logic [31:0]             r_req_addr;
    logic [31:0]             r_rd_data;
    logic                    r_rd_data_valid;

    logic                    w_resp_pending;
    logic                    w_table_hit;
    logic                    w_learn_en;
    logic                    w_subst_en;
    logic [NUM_SLOTS-1:0]    w_match;
    dataslot_even_t          w_even;
    dataslot_odd_t           w_resp_data;

    assign o_bridge_dataslot_out_addr    = i_bridge_dataslot_in_addr;
    assign o_bridge_dataslot_out_wr      = i_bridge_dataslot_in_wr;
    assign o_bridge_dataslot_out_wr_data = i_bridge_dataslot_in_wr_data;
    assign o_bridge_dataslot_out_rd      = i_bridge_dataslot_in_rd;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            REQ_IDLE:    if (i_bridge_dataslot_in_rd) w_next_state = REQ_PENDING;
            REQ_PENDING: begin
                if (i_bridge_dataslot_in_rd)
                    w_next_state = REQ_PENDING;
                else if (i_bridge_dataslot_out_rd_data_valid)
                    w_next_state = REQ_IDLE;
            end
            default:     w_next_state = REQ_IDLE;
        endcase
    end

    // A new rd always overwrites req_addr; the response in the same cycle still sees the old one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= REQ_IDLE;
            r_req_addr <= '0;
        end else begin
            r_state <= w_next_state;
            if (i_bridge_dataslot_in_rd)
                r_req_addr <= i_bridge_dataslot_in_addr;
        end
    end

    assign w_resp_pending = i_bridge_dataslot_out_rd_data_valid && (r_state == REQ_PENDING);
    assign w_table_hit    = ({1'b0, r_req_addr} >= {1'b0, TABLE_BASE}) &&
                            ({1'b0, r_req_addr} <  TABLE_END);
    assign w_learn_en     = w_resp_pending && w_table_hit && (r_req_addr[2:0] == 3'b000);
    assign w_subst_en     = w_resp_pending && (r_req_addr[2:0] == 3'b100);
    assign w_even         = dataslot_even_t'(i_bridge_dataslot_out_rd_data);

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
        bridge_dataslot_size_channel #(
            .SLOT_ID(SLOT_IDS[k])
        ) u_channel (
            .clk            (clk),
            .reset          (reset),
            .i_learn_en     (w_learn_en),
            .i_rd_id        (w_even.id),
            .i_req_addr_hi  (r_req_addr[31:3]),
            .i_size_valid   (i_slot_size_valid[k]),
            .o_base_address (o_slot_base_address[k*32 +: 32]),
            .o_base_found   (o_slot_base_found[k]),
            .o_match        (w_match[k])
        );
    end

    // Walk from the top so the lowest matching channel is applied last and wins.
    always_comb begin
        w_resp_data = dataslot_odd_t'(i_bridge_dataslot_out_rd_data);
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (w_subst_en && w_match[k])
                w_resp_data.size_lower = i_slot_size[k*32 +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data       <= '0;
            r_rd_data_valid <= 1'b0;
        end else begin
            r_rd_data_valid <= i_bridge_dataslot_out_rd_data_valid;
            if (i_bridge_dataslot_out_rd_data_valid)
                r_rd_data <= w_resp_data;
        end
    end

    assign o_bridge_dataslot_in_rd_data       = r_rd_data;
    assign o_bridge_dataslot_in_rd_data_valid = r_rd_data_valid;

endmodule

// File: tb/tb_bridge_dataslot_size_override.sv
// Directed bench for the data-slot size override: learning, substitution,
// table boundaries, overlapping requests and reset during a response.
module tb_bridge_dataslot_size_override;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inAddr;
    logic        inWr;
    logic [31:0] inWrData;
    logic        inRd;
    logic [31:0] inRdData;
    logic        inRdDataValid;
    logic [31:0] outAddr;
    logic        outWr;
    logic [31:0] outWrData;
    logic        outRd;
    logic [31:0] outRdData;
    logic        outRdDataValid;
    logic [63:0] slotSize;
    logic [1:0]  slotSizeValid;
    logic [63:0] slotBaseAddress;
    logic [1:0]  slotBaseFound;

    int checkCount = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    bridge_dataslot_size_override #(
        .NUM_SLOTS     (2),
        .SLOT_IDS      ('{16'd1, 16'd2}),
        .TABLE_BASE    (32'hF800_2000),
        .TABLE_ENTRIES (32)
    ) dut (
        .clk                                 (clk),
        .reset                               (reset),
        .i_bridge_dataslot_in_addr           (inAddr),
        .i_bridge_dataslot_in_wr             (inWr),
        .i_bridge_dataslot_in_wr_data        (inWrData),
        .i_bridge_dataslot_in_rd             (inRd),
        .o_bridge_dataslot_in_rd_data        (inRdData),
        .o_bridge_dataslot_in_rd_data_valid  (inRdDataValid),
        .o_bridge_dataslot_out_addr          (outAddr),
        .o_bridge_dataslot_out_wr            (outWr),
        .o_bridge_dataslot_out_wr_data       (outWrData),
        .o_bridge_dataslot_out_rd            (outRd),
        .i_bridge_dataslot_out_rd_data       (outRdData),
        .i_bridge_dataslot_out_rd_data_valid (outRdDataValid),
        .i_slot_size                         (slotSize),
        .i_slot_size_valid                   (slotSizeValid),
        .o_slot_base_address                 (slotBaseAddress),
        .o_slot_base_found                   (slotBaseFound)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkSlots(input string tag, input logic [1:0] found,
                              input logic [31:0] base0, input logic [31:0] base1);
        checkOutput({tag, "_found"}, {30'd0, slotBaseFound}, {30'd0, found});
        checkOutput({tag, "_base0"}, slotBaseAddress[31:0], base0);
        checkOutput({tag, "_base1"}, slotBaseAddress[63:32], base1);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        inRd = 1'b0;
        outRdDataValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One host read, its response one cycle later, and the upstream result one cycle after that.
    task automatic applyStimulus(input string tag, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [31:0] expected);
        @(negedge clk);
        inAddr = addr;
        inRd   = 1'b1;
        @(negedge clk);
        inRd           = 1'b0;
        outRdDataValid = 1'b1;
        outRdData      = data;
        checkOutput({tag, "_early"}, {31'd0, inRdDataValid}, 32'd0);
        @(negedge clk);
        outRdDataValid = 1'b0;
        checkOutput({tag, "_valid"}, {31'd0, inRdDataValid}, 32'd1);
        checkOutput({tag, "_data"}, inRdData, expected);
    endtask

    initial begin
        reset = 1'b1;
        inAddr = '0; inWr = 1'b0; inWrData = '0; inRd = 1'b0;
        outRdData = '0; outRdDataValid = 1'b0;
        slotSize = {32'hDEAD_BEEF, 32'h0001_2345};
        slotSizeValid = 2'b00;

        doReset();
        checkOutput("rst_valid", {31'd0, inRdDataValid}, 32'd0);
        checkOutput("rst_data", inRdData, 32'd0);
        checkSlots("rst", 2'b00, 32'd0, 32'd0);

        @(negedge clk);
        inAddr = 32'hF800_2010; inWr = 1'b1; inWrData = 32'h1234_5678;
        #1;
        checkOutput("wr_pass", {31'd0, outWr}, 32'd1);
        checkOutput("wr_data_pass", outWrData, 32'h1234_5678);
        checkOutput("addr_pass", outAddr, 32'hF800_2010);
        inWr = 1'b0;
        checkSlots("wr_nolearn", 2'b00, 32'd0, 32'd0);

        applyStimulus("learn0", 32'hF800_2000, 32'h0003_0001, 32'h0003_0001);
        checkSlots("learn0", 2'b01, 32'hF800_2000, 32'd0);

        slotSizeValid = 2'b01;
        applyStimulus("subst0", 32'hF800_2004, 32'h0000_0100, 32'h0001_2345);
        slotSizeValid = 2'b00;
        applyStimulus("nosubst0", 32'hF800_2004, 32'h0000_0100, 32'h0000_0100);

        slotSizeValid = 2'b11;
        applyStimulus("unlearned", 32'hF800_200C, 32'hAAAA_AAAA, 32'hAAAA_AAAA);
        checkSlots("unlearned", 2'b01, 32'hF800_2000, 32'd0);

        applyStimulus("learn1", 32'hF800_2008, 32'h0000_0002, 32'h0000_0002);
        checkSlots("learn1", 2'b11, 32'hF800_2000, 32'hF800_2008);
        applyStimulus("subst1", 32'hF800_200C, 32'hAAAA_AAAA, 32'hDEAD_BEEF);

        doReset();
        checkSlots("rst2", 2'b00, 32'd0, 32'd0);
        applyStimulus("below", 32'hF800_1FF8, 32'h0000_0001, 32'h0000_0001);
        applyStimulus("pastend", 32'hF800_2100, 32'h0000_0001, 32'h0000_0001);
        checkSlots("outside", 2'b00, 32'd0, 32'd0);
        applyStimulus("dup_a", 32'hF800_2008, 32'h0000_0001, 32'h0000_0001);
        applyStimulus("dup_b", 32'hF800_2010, 32'h0000_0001, 32'h0000_0001);
        applyStimulus("lastent", 32'hF800_20F8, 32'h0000_0002, 32'h0000_0002);
        checkSlots("dup", 2'b11, 32'hF800_2008, 32'hF800_20F8);

        slotSizeValid = 2'b01;
        applyStimulus("subst_dup", 32'hF800_200C, 32'h0000_0000, 32'h0001_2345);
        @(negedge clk);
        outRdDataValid = 1'b1;
        outRdData      = 32'h0000_0055;
        @(negedge clk);
        outRdDataValid = 1'b0;
        checkOutput("idle_valid", {31'd0, inRdDataValid}, 32'd1);
        checkOutput("idle_data", inRdData, 32'h0000_0055);

        doReset();
        @(negedge clk);
        inAddr = 32'hF800_2000; inRd = 1'b1;
        @(negedge clk);
        inAddr = 32'hF800_2004; inRd = 1'b1;
        outRdDataValid = 1'b1; outRdData = 32'h0000_0001;
        @(negedge clk);
        inRd = 1'b0;
        outRdDataValid = 1'b1; outRdData = 32'h0000_0100;
        checkOutput("ovl_valid1", {31'd0, inRdDataValid}, 32'd1);
        checkOutput("ovl_data1", inRdData, 32'h0000_0001);
        checkSlots("ovl", 2'b01, 32'hF800_2000, 32'd0);
        @(negedge clk);
        outRdDataValid = 1'b0;
        checkOutput("ovl_valid2", {31'd0, inRdDataValid}, 32'd1);
        checkOutput("ovl_data2", inRdData, 32'h0001_2345);
        @(negedge clk);
        checkOutput("ovl_done", {31'd0, inRdDataValid}, 32'd0);

        @(negedge clk);
        inAddr = 32'hF800_2008; inRd = 1'b1;
        @(negedge clk);
        inRd = 1'b0;
        reset = 1'b1;
        outRdDataValid = 1'b1; outRdData = 32'h0000_0002;
        @(negedge clk);
        reset = 1'b0;
        outRdDataValid = 1'b0;
        checkOutput("rstresp_valid", {31'd0, inRdDataValid}, 32'd0);
        checkOutput("rstresp_data", inRdData, 32'd0);
        checkSlots("rstresp", 2'b00, 32'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
